// File: rtl/mem_access_unit.sv
// rtl/mem_access_unit.sv - single-access data-memory sequencer on a req/ack bus
// Optional MEM_TIMEOUT_EN aborts a request that sees no ack within TIMEOUT cycles.
module mem_access_unit #(
    parameter int AW      = 8,
    parameter int DW      = 8,
    parameter int TIMEOUT = 16
) (
    input  logic          clk_i,
    input  logic          rst_n_i,
    input  logic          start_i,
    input  logic          mem_read_i,
    input  logic          mem_write_i,
    input  logic [AW-1:0] addr_i,
    input  logic [DW-1:0] wdata_i,
    output logic          busy_o,
    output logic          done_o,
    output logic          err_o,
    output logic [DW-1:0] rdata_o,
    output logic          bus_req_o,
    output logic          bus_we_o,
    output logic [AW-1:0] bus_addr_o,
    output logic [DW-1:0] bus_wdata_o,
    input  logic          bus_ack_i,
    input  logic [DW-1:0] bus_rdata_i
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_DONE
    } state_t;

    state_t        state_q;
    logic          busy_q;
    logic          done_q;
    logic          err_q;
    logic          bus_req_q;
    logic          bus_we_q;
    logic [AW-1:0] bus_addr_q;
    logic [DW-1:0] bus_wdata_q;
    logic [DW-1:0] rdata_q;

`ifdef MEM_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT + 1);
    logic [CW-1:0] wait_cnt_q;
    logic          timeout_hit;

    // The current no-ack cycle is the one that brings the count to TIMEOUT.
    assign timeout_hit = (wait_cnt_q == CW'(TIMEOUT - 1));
`else
    logic unused_timeout;
    assign unused_timeout = ^TIMEOUT;
`endif

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q     <= S_IDLE;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            bus_req_q   <= 1'b0;
            bus_we_q    <= 1'b0;
            bus_addr_q  <= '0;
            bus_wdata_q <= '0;
            rdata_q     <= '0;
`ifdef MEM_TIMEOUT_EN
            wait_cnt_q  <= '0;
`endif
        end else begin
            case (state_q)
                S_IDLE: begin
                    done_q <= 1'b0;
                    err_q  <= 1'b0;
                    if (start_i) begin
                        busy_q <= 1'b1;
                        // Exactly one strobe is a legal access; anything else
                        // (including an undecoded X) reports an error.
                        if (mem_read_i ^ mem_write_i) begin
                            state_q     <= S_REQ;
                            bus_req_q   <= 1'b1;
                            bus_we_q    <= mem_write_i;
                            bus_addr_q  <= addr_i;
                            bus_wdata_q <= wdata_i;
`ifdef MEM_TIMEOUT_EN
                            wait_cnt_q  <= '0;
`endif
                        end else begin
                            state_q <= S_DONE;
                            done_q  <= 1'b1;
                            err_q   <= 1'b1;
                        end
                    end
                end
                S_REQ: begin
                    if (bus_ack_i) begin
                        bus_req_q <= 1'b0;
                        if (!bus_we_q) begin
                            rdata_q <= bus_rdata_i;
                        end
                        state_q <= S_DONE;
                        done_q  <= 1'b1;
                        err_q   <= 1'b0;
                    end
`ifdef MEM_TIMEOUT_EN
                    else if (timeout_hit) begin
                        bus_req_q <= 1'b0;
                        state_q   <= S_DONE;
                        done_q    <= 1'b1;
                        err_q     <= 1'b1;
                    end else begin
                        wait_cnt_q <= wait_cnt_q + 1'b1;
                    end
`endif
                end
                S_DONE: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                    err_q   <= 1'b0;
                end
                default: begin
                    state_q   <= S_IDLE;
                    busy_q    <= 1'b0;
                    done_q    <= 1'b0;
                    err_q     <= 1'b0;
                    bus_req_q <= 1'b0;
                end
            endcase
        end
    end

    assign busy_o      = busy_q;
    assign done_o      = done_q;
    assign err_o       = err_q;
    assign rdata_o     = rdata_q;
    assign bus_req_o   = bus_req_q;
    assign bus_we_o    = bus_we_q;
    assign bus_addr_o  = bus_addr_q;
    assign bus_wdata_o = bus_wdata_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// tb/tb_mem_access_unit.sv - randomized self-checking bench for mem_access_unit
// Inputs change and outputs are sampled on the falling clock edge.
module tb_mem_access_unit;

`ifdef MEM_TIMEOUT_EN
    localparam int TO = 4;
`else
    localparam int TO = 16;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       mem_read = 1'b0;
    logic       mem_write = 1'b0;
    logic [7:0] addr = '0;
    logic [7:0] wdata = '0;
    logic       busy;
    logic       done;
    logic       err;
    logic [7:0] rdata;
    logic       bus_req;
    logic       bus_we;
    logic [7:0] bus_addr;
    logic [7:0] bus_wdata;
    logic       bus_ack = 1'b0;
    logic [7:0] bus_rdata = '0;

    int checks = 0;
    int errors = 0;
    logic [7:0] exp_rdata = '0;

    mem_access_unit #(.AW(8), .DW(8), .TIMEOUT(TO)) dut (
        .clk_i       (clk),
        .rst_n_i     (rst_n),
        .start_i     (start),
        .mem_read_i  (mem_read),
        .mem_write_i (mem_write),
        .addr_i      (addr),
        .wdata_i     (wdata),
        .busy_o      (busy),
        .done_o      (done),
        .err_o       (err),
        .rdata_o     (rdata),
        .bus_req_o   (bus_req),
        .bus_we_o    (bus_we),
        .bus_addr_o  (bus_addr),
        .bus_wdata_o (bus_wdata),
        .bus_ack_i   (bus_ack),
        .bus_rdata_i (bus_rdata)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic scramble_inputs();
        start     = 1'($urandom);
        mem_read  = 1'($urandom);
        mem_write = 1'($urandom);
        addr      = 8'($urandom);
        wdata     = 8'($urandom);
    endtask

    // Caller is at a falling edge with the DUT idle; returns at the falling
    // edge of the first idle cycle after done, ready for a back-to-back start.
    task automatic do_access(input logic rd, input logic wr, input logic [7:0] a,
                             input logic [7:0] wd, input int dly, input logic [7:0] rv);
        logic valid;
        valid = rd ^ wr;
        chk("idle_busy", busy, 0);
        start = 1'b1; mem_read = rd; mem_write = wr; addr = a; wdata = wd;
        @(negedge clk);
        scramble_inputs();
        if (valid) begin
            chk("req_on", bus_req, 1);
            chk("req_we", bus_we, wr);
            chk("req_addr", bus_addr, a);
            chk("req_wdata", bus_wdata, wd);
            chk("req_done", done, 0);
            for (int i = 0; i < dly; i++) begin
                @(negedge clk);
                scramble_inputs();
                chk("hold_req", bus_req, 1);
                chk("hold_addr", bus_addr, a);
                chk("hold_busy", busy, 1);
            end
            bus_ack = 1'b1; bus_rdata = rv;
            @(negedge clk);
            bus_ack = 1'b0; bus_rdata = 8'($urandom);
            scramble_inputs();
            if (rd) exp_rdata = rv;
            chk("done_pulse", done, 1);
            chk("done_err", err, 0);
        end else begin
            chk("inv_done", done, 1);
            chk("inv_err", err, 1);
        end
        chk("done_busy", busy, 1);
        chk("done_noreq", bus_req, 0);
        chk("done_rdata", rdata, exp_rdata);
        bus_ack = 1'($urandom);
        @(negedge clk);
        bus_ack = 1'b0;
        start = 1'b0;
        chk("after_done", done, 0);
        chk("after_err", err, 0);
        chk("after_busy", busy, 0);
        chk("after_req", bus_req, 0);
        chk("after_rdata", rdata, exp_rdata);
    endtask

    initial begin
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_req", bus_req, 0);
        chk("rst_rdata", rdata, 0);
        chk("rst_addr", bus_addr, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        do_access(1, 0, 8'h3C, 8'h00, 2, 8'hA5);
        do_access(0, 1, 8'h10, 8'h5A, 0, 8'hFF);
        do_access(1, 1, 8'h20, 8'h11, 0, 8'h00);
        do_access(0, 0, 8'h21, 8'h22, 0, 8'h00);

`ifdef MEM_TIMEOUT_EN
        start = 1'b1; mem_read = 1'b1; mem_write = 1'b0; addr = 8'h77;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < TO; i++) begin
            chk("to_req", bus_req, 1);
            @(negedge clk);
        end
        chk("to_done", done, 1);
        chk("to_err", err, 1);
        chk("to_noreq", bus_req, 0);
        chk("to_rdata", rdata, exp_rdata);
        @(negedge clk);
        chk("to_after", done, 0);
`endif

        start = 1'b1; mem_read = 1'b1; mem_write = 1'b0; addr = 8'h44;
        @(negedge clk);
        start = 1'b0;
        chk("mid_req", bus_req, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_req", bus_req, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_done", done, 0);
        exp_rdata = '0;
        chk("mid_rst_rdata", rdata, exp_rdata);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_done", done, 0);
        do_access(1, 0, 8'h45, 8'h00, 1, 8'h3E);

        do_access(0, 1, 8'h80, 8'hC3, 1, 8'h00);
        do_access(1, 0, 8'h81, 8'h00, 0, 8'h96);

        for (int n = 0; n < 60; n++) begin
            int kind;
            kind = int'($urandom_range(0, 9));
            do_access(kind < 4 || kind == 8, (kind >= 4 && kind < 8) || kind == 8,
                      8'($urandom), 8'($urandom), int'($urandom_range(0, 3)), 8'($urandom));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
